// File: rtl/seq_pkg.sv
// Shared definitions for the pattern_serializer / sequence_detector pair.
//
// Contents:
//   MAX_LEN     - longest serial pattern handled, in bits
//   LEN_W       - width of a bit count able to hold 0..MAX_LEN
//   ser_state_t - serializer FSM states (IDLE, SHIFT, DONE)
package seq_pkg;

  localparam int MAX_LEN = 24;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/bit_period_divider.sv
// Bit-period down-counter for the pattern serializer.
//
// Ports:
//   clk  - system clock, posedge
//   rst  - synchronous active-low reset, clears the counter
//   ena  - count enable (global enable already qualified with "shifting")
//   load - reload the counter from div, independent of ena
//   div  - reload value = cycles per bit minus 1
//   tick - high in the last enabled cycle of a bit period
module bit_period_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  // The tick is qualified by ena so a frozen period never produces a strobe;
  // the counter holds at zero and the tick fires once ena returns.
  assign tick = ena && (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load || tick) begin
      cnt_reg <= div;
    end else if (ena) begin
      // Non-zero here, since a zero count with ena set is a tick.
      cnt_reg <= cnt_reg - DIV_W'(1);
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial test pattern generator feeding sequence_detector.
//
// A pattern of up to MAX_LEN bits is captured on an accepted start and sent
// LSB first on sig_out, each bit held for bit_div+1 enabled cycles.
//
// Ports:
//   clk        - system clock, posedge
//   rst        - synchronous active-low reset (overrides ena and start)
//   ena        - global enable; 0 freezes all state
//   start      - begin a transfer (only honoured in IDLE)
//   pattern    - bits to send, pattern[0] first
//   len        - number of bits; values above MAX_LEN clamp to MAX_LEN
//   bit_div    - cycles per bit minus 1
//   sig_out    - serial data, 0 outside a transfer
//   bit_strobe - high in the final cycle of each bit period
//   busy       - high while bits are being sent
//   ready      - high in IDLE
//   done       - one-cycle pulse at the end of a transfer
module pattern_serializer #(
  parameter int MAX_LEN = seq_pkg::MAX_LEN,
  parameter int LEN_W   = seq_pkg::LEN_W,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [DIV_W-1:0]   bit_div,
  output logic               sig_out,
  output logic               bit_strobe,
  output logic               busy,
  output logic               ready,
  output logic               done
);

  import seq_pkg::*;

  ser_state_t         state_reg, state_next;
  logic [MAX_LEN-1:0] shreg_reg, shreg_next;
  logic [LEN_W-1:0]   rem_reg, rem_next;
  logic [DIV_W-1:0]   div_reg, div_next;

  logic               sig_out_reg, sig_out_next;
  logic               busy_reg, busy_next;
  logic               ready_reg, ready_next;
  logic               done_reg, done_next;

  logic               load;
  logic               tick;
  logic               div_ena;
  logic [DIV_W-1:0]   div_sel;
  logic [LEN_W-1:0]   len_clamped;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  // The divider only runs while shifting. On the load cycle it takes the
  // live bit_div; afterwards it reloads from the copy captured at start, so
  // later changes on bit_div cannot disturb a transfer.
  assign div_ena = ena && (state_reg == SHIFT);
  assign div_sel = load ? bit_div : div_reg;

  bit_period_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .ena  (div_ena),
    .load (load),
    .div  (div_sel),
    .tick (tick)
  );

  // State register (plus datapath and registered outputs).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      rem_reg     <= '0;
      div_reg     <= '0;
      sig_out_reg <= 1'b0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
    end else if (ena) begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      rem_reg     <= rem_next;
      div_reg     <= div_next;
      sig_out_reg <= sig_out_next;
      busy_reg    <= busy_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    rem_next   = rem_reg;
    div_next   = div_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        // ena is part of load because the divider loads regardless of ena.
        if (start && ena) begin
          if (len != '0) begin
            state_next = SHIFT;
            shreg_next = pattern;
            rem_next   = len_clamped;
            div_next   = bit_div;
            load       = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          shreg_next = shreg_reg >> 1;
          rem_next   = rem_reg - LEN_W'(1);
          if (rem_reg == LEN_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: computed from the upcoming state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    sig_out_next = 1'b0;
    busy_next    = 1'b0;
    ready_next   = 1'b0;
    done_next    = 1'b0;
    case (state_next)
      IDLE:    ready_next = 1'b1;
      SHIFT: begin
        busy_next    = 1'b1;
        sig_out_next = shreg_next[0];
      end
      DONE:    done_next = 1'b1;
      default: ready_next = 1'b1;
    endcase
  end

  assign sig_out    = sig_out_reg;
  assign busy       = busy_reg;
  assign ready      = ready_reg;
  // Pulses are masked while frozen; a held DONE state re-emits done later.
  assign done       = done_reg & ena;
  assign bit_strobe = tick;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: directed cases plus random transfers with a
// randomly toggling enable, checked by a scoreboard monitor.
module tb_pattern_serializer;

  localparam int ML = 24;
  localparam int LW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic          start = 1'b0;
  logic [ML-1:0] pattern = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] bit_div = '0;
  logic          sig_out, bit_strobe, busy, ready, done;

  pattern_serializer #(
    .MAX_LEN (ML),
    .LEN_W   (LW),
    .DIV_W   (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .bit_div    (bit_div),
    .sig_out    (sig_out),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .ready      (ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ML-1:0] bits;
    int            nbits;
    int            div;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_active = 1'b0;
  bit   mon_pend_done = 1'b0;
  bit   rand_ena = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops expected transfers when the DUT starts presenting them and
  // checks every bit, every bit period, busy length and done placement.
  initial begin : monitor
    txn_t cur;
    int   idx;
    int   gap;
    int   bcnt;
    idx = 0; gap = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        mon_active    = 1'b0;
        mon_pend_done = 1'b0;
        gap           = 0;
        continue;
      end
      if (mon_pend_done && ena) begin
        chk("done_after_last_strobe", done, 1);
        chk("busy_enabled_cycles", bcnt, cur.nbits * (cur.div + 1));
        $display("txn: len=%0d div=%0d pattern=%06h busy_en_cycles=%0d",
                 cur.nbits, cur.div, cur.bits, bcnt);
        mon_pend_done = 1'b0;
        mon_active    = 1'b0;
      end else if (done) begin
        if (!mon_active && exp_q.size() > 0 && exp_q[0].nbits == 0) begin
          void'(exp_q.pop_front());
          chk("empty_txn_busy", busy, 0);
          $display("txn: len=0 done only");
        end else begin
          chk("unexpected_done", done, 0);
        end
      end
      if (busy) begin
        if (!mon_active) begin
          if (exp_q.size() == 0 || exp_q[0].nbits == 0) begin
            chk("unexpected_busy", busy, 0);
          end else begin
            cur = exp_q.pop_front();
            mon_active = 1'b1;
            idx = 0; gap = 0; bcnt = 0;
          end
        end
        if (mon_active) begin
          if (idx < cur.nbits) chk("sig_out_bit", sig_out, cur.bits[idx]);
          if (ena) begin
            gap++;
            bcnt++;
          end
        end
      end else begin
        chk("sig_out_idle_low", sig_out, 0);
      end
      if (bit_strobe) begin
        if (!mon_active || !busy) begin
          chk("strobe_outside_transfer", bit_strobe, 0);
        end else if (idx >= cur.nbits) begin
          chk("extra_strobe", idx, cur.nbits - 1);
        end else begin
          chk("bit_period", gap, cur.div + 1);
          gap = 0;
          idx++;
          if (idx == cur.nbits) mon_pend_done = 1'b1;
        end
      end
      if (ena) chk("ready_vs_busy_done", ready, !(busy || done));
    end
  end

  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      ena = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick_cycle();
      n++;
    end
    chk("wait_ready_timeout", ready === 1'b1, 1);
    ena = 1'b1;
  endtask

  // Reference model: the expected transfer is just the first min(len,24)
  // bits of the pattern, each held div+1 enabled cycles.
  task automatic send(input logic [ML-1:0] pat, input int l, input int d);
    txn_t t;
    logic [7:0] lv;
    logic [7:0] dv;
    wait_ready(3000);
    lv = l[7:0];
    dv = d[7:0];
    t.bits  = pat;
    t.nbits = (l > ML) ? ML : l;
    t.div   = d;
    exp_q.push_back(t);
    start   = 1'b1;
    pattern = pat;
    len     = lv[LW-1:0];
    bit_div = dv;
    tick_cycle();
    start   = 1'b0;
    pattern = $urandom;
    len     = LW'($urandom);
    bit_div = DW'($urandom);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    rst = 1'b0;
    ena = 1'b1;
    repeat (3) tick_cycle();
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_sig_out", sig_out, 0);
    chk("reset_done", done, 0);
    chk("reset_strobe", bit_strobe, 0);
    rst = 1'b1;

    // Case 1: one bit per cycle, full length.
    send(24'hCAE8C8, 24, 0);

    // Case 2: four cycles per bit.
    send(24'h00000A, 4, 3);

    // Case 3: freeze for 5 cycles during the second bit.
    send(24'h00000A, 4, 3);
    repeat (5) tick_cycle();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("frozen_sig_out", sig_out, 1);
      chk("frozen_no_strobe", bit_strobe, 0);
      chk("frozen_busy", busy, 1);
      tick_cycle();
    end
    ena = 1'b1;

    // Case 4: a second start mid-transfer is ignored.
    send(24'hCAE8C8, 24, 0);
    repeat (6) tick_cycle();
    start = 1'b1; pattern = 24'h5A5A5A; len = 5'd5; bit_div = 8'd2;
    tick_cycle();
    start = 1'b0;

    // Zero-length start, then a start during the DONE cycle (ignored).
    send(24'hFFFFFF, 0, 0);
    chk("len0_done_pulse", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_sig_out", sig_out, 0);
    start = 1'b1; pattern = 24'h000007; len = 5'd3; bit_div = 8'd0;
    tick_cycle();
    start = 1'b0;

    // Case 5: reset during bit 10 aborts with no done, then replay.
    send(24'hCAE8C8, 24, 0);
    repeat (9) tick_cycle();
    rst = 1'b0;
    tick_cycle();
    chk("abort_sig_out", sig_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    rst = 1'b1;
    send(24'hCAE8C8, 24, 0);

    // Case 6: oversize length clamps to 24.
    send(24'hFFFFFF, 31, 0);

    // Random transfers with a randomly gated enable.
    rand_ena = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send(ML'($urandom), $urandom_range(0, 31), $urandom_range(0, 5));
    end
    rand_ena = 1'b0;
    wait_ready(3000);
    repeat (3) tick_cycle();

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("no_pending_txn", mon_active || mon_pend_done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Upstream stimulus stage for sequence_detector.
- Captures a parallel test pattern of up to MAX_LEN bits and shifts it out serially on sig_out, pattern[0] first.
- Each bit is held for a programmable number of clock cycles.
- sig_out feeds sig_to_test. bit_strobe may drive the detector's ena, so the detector samples exactly one value per bit.

Parameters:
- MAX_LEN, 24: maximum pattern length in bits.
- LEN_W, 5: width of len; equals $clog2(MAX_LEN+1).
- DIV_W, 8: width of bit_div.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- ena  in  1  global enable; 0 freezes all state, counters and outputs.
- start  in  1  request to begin a transfer; sampled only in IDLE.
- pattern  in  MAX_LEN  bits to send; pattern[0] is sent first.
- len  in  LEN_W  number of bits to send; values above MAX_LEN are clamped to MAX_LEN.
- bit_div  in  DIV_W  cycles per bit minus 1 (0 = one bit per cycle).
- sig_out  out  1  serial data.
- bit_strobe  out  1  high in the final cycle of each bit period.
- busy  out  1  high while bits are being sent.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse at the end of a transfer.

Behaviour:
- Reset (rst=0 at a posedge), effective from the next edge, overriding ena and start:
  - state=IDLE.
  - sig_out=0, bit_strobe=0, busy=0, done=0, ready=1.
  - shift register, bit counter and divider all cleared.
  - A reset mid-transfer aborts it with no done pulse.
- States are IDLE, SHIFT, DONE; all outputs are registered.
- IDLE:
  - ready=1, sig_out=0.
  - start=1 & ena=1 & len!=0: load shreg<=pattern, remaining<=min(len,MAX_LEN), div_cnt<=bit_div, go to SHIFT.
  - sig_out=pattern[0] from the next cycle (latency 1).
  - start=1 & ena=1 & len==0: go to DONE; no bits sent and busy stays 0.
- SHIFT:
  - busy=1, ready=0, sig_out=shreg[0].
  - Each ena cycle: if div_cnt!=0, decrement it.
  - If div_cnt==0: bit_strobe=1 this cycle; next edge shreg>>=1, remaining-=1, div_cnt<=bit_div.
  - If remaining==1 at a strobe, go to DONE.
- DONE:
  - done=1 for one cycle, busy=0, sig_out=0.
  - Next state IDLE. A start in this cycle is ignored.
- Transfer timing:
  - Each bit is stable for exactly bit_div+1 enabled cycles.
  - busy lasts len*(bit_div+1) enabled cycles.
  - done follows one cycle after the last strobe.
- pattern, len and bit_div are sampled only at start acceptance. Changes during a transfer have no effect.
- start asserted while busy or in DONE is ignored and not queued.
- ena=0 in any state:
  - all registers hold.
  - bit_strobe and done are forced to 0 while ena=0; a pending done pulse is emitted once ena returns.
  - sig_out and busy hold their values.
- Arithmetic: remaining is LEN_W bits; div_cnt is DIV_W bits with no wrap. Clamping happens at load.

Decomposition:
- Package seq_pkg:
  - ser_state_t enum {IDLE, SHIFT, DONE}, 2 bits.
  - MAX_LEN and LEN_W localparams, shared with sequence_detector benches.
- Sub-module bit_period_divider:
  - Ports: clk, rst, ena, load, div, tick.
  - Down-counter that reloads on load or tick; tick drives bit_strobe.
- The top holds the FSM, shift register and bit counter.

Test Plan:
1. bit_div=0, len=24, pattern=24'hCAE8C8, 1-cycle start:
   - sig_out over 24 consecutive cycles = 0,0,0,1,0,0,1,1,0,0,0,1,0,1,1,1,0,1,0,1,0,0,1,1.
   - bit_strobe high in all 24 cycles, busy for 24 cycles, done in cycle 25, ready again in cycle 26.
2. bit_div=3, len=4, pattern=4'b1010:
   - sig_out = 0,1,0,1, each held 4 cycles.
   - bit_strobe on cycles 4, 8, 12, 16; busy for 16 cycles; single done pulse.
3. Case 2 with ena=0 for 5 cycles during the second bit:
   - sig_out stays 1 and no strobe fires while ena=0.
   - busy is extended to 21 cycles; the bit sequence is unchanged.
4. start pulsed again during a case-1 transfer: ignored, output identical to case 1.
   - Then len=0 with start: done pulses next cycle, busy never asserts, sig_out stays 0.
5. rst=0 during bit 10 of case 1:
   - Next edge: sig_out=0, busy=0, ready=1, no done.
   - A new start afterwards replays case 1 exactly.
6. len=31, pattern=24'hFFFFFF, bit_div=0: exactly 24 ones are sent, then done (len clamped to 24).
